// File: rtl/sync_token_hub.sv
// Per-channel producer/consumer occupancy token counters with empty/full decode.
// Optional sticky ovf/udf error flags are built when SYNC_HUB_ERR_EN is defined.
module sync_token_hub #(
  parameter int NumChan    = 4,
  parameter int TokenDepth = 2,
  parameter int InitCnt    = 0,
  parameter int CntW       = $clog2(TokenDepth + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NumChan-1:0]            wSync,
  input  logic [NumChan-1:0]            rSync,
  input  logic [NumChan-1:0]            flush,
  output logic [NumChan-1:0]            empty,
  output logic [NumChan-1:0]            full,
  output logic [NumChan-1:0][CntW-1:0]  count,
  output logic [NumChan-1:0]            ovfErr,
  output logic [NumChan-1:0]            udfErr,
  input  logic                          clrErr
);

  localparam logic [CntW-1:0] DepthC = CntW'(TokenDepth);
  localparam logic [CntW-1:0] InitC  = CntW'(InitCnt);

  logic [NumChan-1:0][CntW-1:0] countReg;

  genvar gi;
  generate
    for (gi = 0; gi < NumChan; gi++) begin : gChan
      logic wLegal;
      logic rLegal;

      // Legality is judged against the pre-state count only.
      assign wLegal = wSync[gi] && (countReg[gi] != DepthC);
      assign rLegal = rSync[gi] && (countReg[gi] != '0);

      always_ff @(posedge clk) begin
        if (rst) begin
          countReg[gi] <= InitC;
        end else if (flush[gi]) begin
          countReg[gi] <= InitC;
        end else if (wLegal && !rLegal) begin
          countReg[gi] <= countReg[gi] + 1'b1;
        end else if (rLegal && !wLegal) begin
          countReg[gi] <= countReg[gi] - 1'b1;
        end
      end

      assign count[gi] = countReg[gi];
      assign empty[gi] = (countReg[gi] == '0);
      assign full[gi]  = (countReg[gi] == DepthC);

`ifdef SYNC_HUB_ERR_EN
      logic ovfReg;
      logic udfReg;

      // A new error takes priority over clrErr; syncs dropped by flush are not errors.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovfReg <= 1'b0;
          udfReg <= 1'b0;
        end else begin
          if (wSync[gi] && !wLegal && !flush[gi]) begin
            ovfReg <= 1'b1;
          end else if (clrErr) begin
            ovfReg <= 1'b0;
          end
          if (rSync[gi] && !rLegal && !flush[gi]) begin
            udfReg <= 1'b1;
          end else if (clrErr) begin
            udfReg <= 1'b0;
          end
        end
      end

      assign ovfErr[gi] = ovfReg;
      assign udfErr[gi] = udfReg;

`ifndef SYNTHESIS
      always_ff @(posedge clk) begin
        if (!rst && !flush[gi]) begin
          assert (!(wSync[gi] && !wLegal) && !(rSync[gi] && !rLegal));
        end
      end
`endif
`else
      assign ovfErr[gi] = clrErr & 1'b0;
      assign udfErr[gi] = clrErr & 1'b0;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_sync_token_hub.sv
// Directed bench for sync_token_hub: default instance (Depth 2, Init 0)
// plus a second instance with Depth 3, Init 1.
module tb_sync_token_hub;

`ifdef SYNC_HUB_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, clrErr;
  logic [3:0] wSync, rSync, flush;
  logic [3:0] empty, full, ovfErr, udfErr;
  logic [3:0][1:0] count;

  logic [3:0] wSync1, rSync1, flush1;
  logic [3:0] empty1, full1, ovfErr1, udfErr1;
  logic [3:0][1:0] count1;

  int total = 0;
  int bad = 0;

  sync_token_hub #(.NumChan(4), .TokenDepth(2), .InitCnt(0)) dut0 (
    .clk(clk), .rst(rst), .wSync(wSync), .rSync(rSync), .flush(flush),
    .empty(empty), .full(full), .count(count), .ovfErr(ovfErr),
    .udfErr(udfErr), .clrErr(clrErr)
  );

  sync_token_hub #(.NumChan(4), .TokenDepth(3), .InitCnt(1)) dut1 (
    .clk(clk), .rst(rst), .wSync(wSync1), .rSync(rSync1), .flush(flush1),
    .empty(empty1), .full(full1), .count(count1), .ovfErr(ovfErr1),
    .udfErr(udfErr1), .clrErr(clrErr)
  );

  // Apply the currently driven inputs for one edge, then clear all pulses.
  task automatic step();
    @(posedge clk);
    #1;
    rst = 0; clrErr = 0;
    wSync = 0; rSync = 0; flush = 0;
    wSync1 = 0; rSync1 = 0; flush1 = 0;
  endtask

  task automatic test_reset();
    rst = 1; step();
    total++; if (count !== 8'h00) begin bad++; $display("FAIL reset_count got=%h exp=%h", count, 8'h00); end
    total++; if (empty !== 4'hF) begin bad++; $display("FAIL reset_empty got=%b exp=%b", empty, 4'hF); end
    total++; if (full !== 4'h0) begin bad++; $display("FAIL reset_full got=%b exp=%b", full, 4'h0); end
    total++; if ({ovfErr, udfErr} !== 8'h00) begin bad++; $display("FAIL reset_errs got=%h exp=%h", {ovfErr, udfErr}, 8'h00); end
    total++; if (count1 !== 8'h55) begin bad++; $display("FAIL reset1_count got=%h exp=%h", count1, 8'h55); end
    total++; if ({empty1, full1} !== 8'h00) begin bad++; $display("FAIL reset1_flags got=%h exp=%h", {empty1, full1}, 8'h00); end
    $display("reset: count=%h empty=%b dut1 count=%h", count, empty, count1);
  endtask

  task automatic test_fill();
    wSync = 4'b0001; step();
    total++; if (count !== 8'h01) begin bad++; $display("FAIL fill1_count got=%h exp=%h", count, 8'h01); end
    total++; if (empty !== 4'hE) begin bad++; $display("FAIL fill1_empty got=%b exp=%b", empty, 4'hE); end
    wSync = 4'b0001; step();
    total++; if (count !== 8'h02) begin bad++; $display("FAIL fill2_count got=%h exp=%h", count, 8'h02); end
    total++; if (full !== 4'b0001) begin bad++; $display("FAIL fill2_full got=%b exp=%b", full, 4'b0001); end
    $display("fill: count=%h full=%b", count, full);
  endtask

  task automatic test_overflow();
    wSync = 4'b0010; step();
    wSync = 4'b0010; step();
    total++; if (count !== 8'h0A) begin bad++; $display("FAIL ovf_pre_count got=%h exp=%h", count, 8'h0A); end
    wSync = 4'b0010; step();
    total++; if (count !== 8'h0A) begin bad++; $display("FAIL ovf_count got=%h exp=%h", count, 8'h0A); end
    total++; if (ovfErr !== {2'b00, ErrEn, 1'b0}) begin bad++; $display("FAIL ovf_flag got=%b exp=%b", ovfErr, {2'b00, ErrEn, 1'b0}); end
    step();
    total++; if (ovfErr !== {2'b00, ErrEn, 1'b0}) begin bad++; $display("FAIL ovf_sticky got=%b exp=%b", ovfErr, {2'b00, ErrEn, 1'b0}); end
    clrErr = 1; step();
    total++; if (ovfErr !== 4'h0) begin bad++; $display("FAIL ovf_clr got=%b exp=%b", ovfErr, 4'h0); end
    $display("overflow: count=%h ovfErr=%b", count, ovfErr);
  endtask

  task automatic test_both_boundary();
    // ch1 full: read applies, write is illegal
    wSync = 4'b0010; rSync = 4'b0010; step();
    total++; if (count !== 8'h06) begin bad++; $display("FAIL full_pair_count got=%h exp=%h", count, 8'h06); end
    total++; if (ovfErr !== {2'b00, ErrEn, 1'b0}) begin bad++; $display("FAIL full_pair_ovf got=%b exp=%b", ovfErr, {2'b00, ErrEn, 1'b0}); end
    clrErr = 1; step();
    // ch2 empty: write applies, read is illegal
    wSync = 4'b0100; rSync = 4'b0100; step();
    total++; if (count !== 8'h16) begin bad++; $display("FAIL empty_pair_count got=%h exp=%h", count, 8'h16); end
    total++; if (udfErr !== {1'b0, ErrEn, 2'b00}) begin bad++; $display("FAIL empty_pair_udf got=%b exp=%b", udfErr, {1'b0, ErrEn, 2'b00}); end
    clrErr = 1; step();
    wSync = 4'b0100; rSync = 4'b0100; step();
    total++; if (count !== 8'h16) begin bad++; $display("FAIL mid_pair_count got=%h exp=%h", count, 8'h16); end
    total++; if ({ovfErr, udfErr} !== 8'h00) begin bad++; $display("FAIL mid_pair_errs got=%h exp=%h", {ovfErr, udfErr}, 8'h00); end
    // clrErr together with a new overflow on ch0: the set wins
    wSync = 4'b0001; clrErr = 1; step();
    total++; if (ovfErr !== {3'b000, ErrEn}) begin bad++; $display("FAIL clr_vs_set got=%b exp=%b", ovfErr, {3'b000, ErrEn}); end
    clrErr = 1; step();
    $display("boundary: count=%h ovfErr=%b udfErr=%b", count, ovfErr, udfErr);
  endtask

  task automatic test_flush();
    wSync = 4'b1000; step();
    wSync = 4'b1000; step();
    total++; if (count !== 8'h96) begin bad++; $display("FAIL flush_pre_count got=%h exp=%h", count, 8'h96); end
    flush = 4'b1000; rSync = 4'b1000; step();
    total++; if (count !== 8'h16) begin bad++; $display("FAIL flush_count got=%h exp=%h", count, 8'h16); end
    total++; if (udfErr !== 4'h0) begin bad++; $display("FAIL flush_udf got=%b exp=%b", udfErr, 4'h0); end
    total++; if (empty !== 4'b1000) begin bad++; $display("FAIL flush_empty got=%b exp=%b", empty, 4'b1000); end
    flush1 = 4'b0001; wSync1 = 4'b0001; step();
    total++; if (count1 !== 8'h55) begin bad++; $display("FAIL flush1_count got=%h exp=%h", count1, 8'h55); end
    $display("flush: count=%h dut1 count=%h", count, count1);
  endtask

  task automatic test_back_to_back();
    rSync = 4'b0001; step();
    total++; if (count !== 8'h15) begin bad++; $display("FAIL b2b_r1 got=%h exp=%h", count, 8'h15); end
    rSync = 4'b0001; step();
    total++; if (count !== 8'h14) begin bad++; $display("FAIL b2b_r2 got=%h exp=%h", count, 8'h14); end
    total++; if (empty !== 4'b1001) begin bad++; $display("FAIL b2b_empty got=%b exp=%b", empty, 4'b1001); end
    rSync = 4'b0001; step();
    total++; if (count !== 8'h14) begin bad++; $display("FAIL b2b_r3 got=%h exp=%h", count, 8'h14); end
    total++; if (udfErr !== {3'b000, ErrEn}) begin bad++; $display("FAIL b2b_udf got=%b exp=%b", udfErr, {3'b000, ErrEn}); end
    $display("back_to_back: count=%h udfErr=%b", count, udfErr);
  endtask

  task automatic test_mid_reset();
    wSync = 4'hF; wSync1 = 4'hF; step();
    total++; if (count !== 8'h69) begin bad++; $display("FAIL mr_count got=%h exp=%h", count, 8'h69); end
    total++; if (count1 !== 8'hAA) begin bad++; $display("FAIL mr1_count got=%h exp=%h", count1, 8'hAA); end
    wSync = 4'b0010; wSync1 = 4'hF; step();
    total++; if (ovfErr !== {2'b00, ErrEn, 1'b0}) begin bad++; $display("FAIL mr_ovf got=%b exp=%b", ovfErr, {2'b00, ErrEn, 1'b0}); end
    total++; if (full1 !== 4'hF) begin bad++; $display("FAIL mr1_full got=%b exp=%b", full1, 4'hF); end
    rst = 1; wSync = 4'hF; rSync = 4'h3; wSync1 = 4'h5; step();
    total++; if (count !== 8'h00) begin bad++; $display("FAIL mr_rst_count got=%h exp=%h", count, 8'h00); end
    total++; if ({ovfErr, udfErr} !== 8'h00) begin bad++; $display("FAIL mr_rst_errs got=%h exp=%h", {ovfErr, udfErr}, 8'h00); end
    total++; if (empty !== 4'hF) begin bad++; $display("FAIL mr_rst_empty got=%b exp=%b", empty, 4'hF); end
    total++; if (count1 !== 8'h55) begin bad++; $display("FAIL mr1_rst_count got=%h exp=%h", count1, 8'h55); end
    total++; if ({empty1, full1} !== 8'h00) begin bad++; $display("FAIL mr1_rst_flags got=%h exp=%h", {empty1, full1}, 8'h00); end
    $display("mid_reset: count=%h dut1 count=%h", count, count1);
  endtask

  initial begin
    rst = 0; clrErr = 0;
    wSync = 0; rSync = 0; flush = 0;
    wSync1 = 0; rSync1 = 0; flush1 = 0;
    test_reset();
    test_fill();
    test_overflow();
    test_both_boundary();
    test_flush();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
